// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared constants for the RV32I ALU (operation codes, branch
// class prefix, datapath width).
package rv_alu_pkg;

    localparam int DATA_W = 32;

    // ALU_Control operation codes
    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_BEQ  = 6'b010000;
    localparam logic [5:0] ALU_BNE  = 6'b010001;
    localparam logic [5:0] ALU_BLT  = 6'b010100;
    localparam logic [5:0] ALU_BGE  = 6'b010101;
    localparam logic [5:0] ALU_BLTU = 6'b010110;
    localparam logic [5:0] ALU_BGEU = 6'b010111;
    localparam logic [5:0] ALU_JAL  = 6'b011111;
    localparam logic [5:0] ALU_JALR = 6'b111111;

    // Upper three bits shared by every conditional-branch code
    localparam logic [2:0] BR_CLASS = 3'b010;

endpackage

// File: rtl/rv_alu_cmp.sv
// rv_alu_cmp: equality / signed-less-than / unsigned-less-than comparator
// shared by SLT/SLTU and the branch decode.
module rv_alu_cmp
    import rv_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              eq_o,
    output logic              lt_o,
    output logic              ltu_o
);

    // Pure combinational comparisons
    always_comb begin
        eq_o  = (a_i == b_i);
        lt_o  = ($signed(a_i) < $signed(b_i));
        ltu_o = (a_i < b_i);
    end

endmodule

// File: rtl/rv_alu.sv
// rv_alu: 32-bit RV32I ALU with combinational result/branch and a registered
// copy of both. Optional macro ALU_ZERO_FLAG_EN adds zero / zero_q outputs.
module rv_alu
    import rv_alu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_op,
    input  logic [5:0]        ALU_Control,
    input  logic [DATA_W-1:0] operand_A,
    input  logic [DATA_W-1:0] operand_B,
    output logic [DATA_W-1:0] ALU_result,
    output logic              branch,
`ifdef ALU_ZERO_FLAG_EN
    output logic              zero,
    output logic              zero_q,
`endif
    output logic [DATA_W-1:0] ALU_result_q,
    output logic              branch_q
);

    logic       cmp_eq, cmp_lt, cmp_ltu;
    logic [4:0] shamt;
    logic       cmp_true;

    assign shamt = operand_B[4:0];

    rv_alu_cmp u_cmp (
        .a_i   (operand_A),
        .b_i   (operand_B),
        .eq_o  (cmp_eq),
        .lt_o  (cmp_lt),
        .ltu_o (cmp_ltu)
    );

    // Operation select; compare results are zero-extended into bit 0
    always_comb begin
        ALU_result = '0;
        cmp_true   = 1'b0;
        case (ALU_Control)
            ALU_ADD:  ALU_result = operand_A + operand_B;
            ALU_SUB:  ALU_result = operand_A - operand_B;
            ALU_SLL:  ALU_result = operand_A << shamt;
            ALU_SRL:  ALU_result = operand_A >> shamt;
            ALU_SRA:  ALU_result = $unsigned($signed(operand_A) >>> shamt);
            ALU_SLT:  ALU_result = {{(DATA_W-1){1'b0}}, cmp_lt};
            ALU_SLTU: ALU_result = {{(DATA_W-1){1'b0}}, cmp_ltu};
            ALU_XOR:  ALU_result = operand_A ^ operand_B;
            ALU_OR:   ALU_result = operand_A | operand_B;
            ALU_AND:  ALU_result = operand_A & operand_B;
            ALU_BEQ:  cmp_true   = cmp_eq;
            ALU_BNE:  cmp_true   = ~cmp_eq;
            ALU_BLT:  cmp_true   = cmp_lt;
            ALU_BGE:  cmp_true   = ~cmp_lt;
            ALU_BLTU: cmp_true   = cmp_ltu;
            ALU_BGEU: cmp_true   = ~cmp_ltu;
            ALU_JAL,
            ALU_JALR: ALU_result = operand_A;
            default:  ALU_result = '0;
        endcase
        if (ALU_Control[5:3] == BR_CLASS)
            ALU_result = {{(DATA_W-1){1'b0}}, cmp_true};
    end

    // Branch is taken only for a real branch instruction with a branch-class code
    assign branch = branch_op && (ALU_Control[5:3] == BR_CLASS) && cmp_true;

`ifdef ALU_ZERO_FLAG_EN
    assign zero = (ALU_result == '0);

    // Registered zero flag; resets to 1 to match a cleared result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) zero_q <= 1'b1;
        else        zero_q <= zero;
    end
`endif

    // Registered taps for writeback/debug, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ALU_result_q <= '0;
            branch_q     <= 1'b0;
        end else begin
            ALU_result_q <= ALU_result;
            branch_q     <= branch;
        end
    end

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: self-checking bench for rv_alu (directed table + random vs model).
module tb_rv_alu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        branch_op = 1'b0;
    logic [5:0]  ALU_Control = '0;
    logic [31:0] operand_A = '0;
    logic [31:0] operand_B = '0;
    logic [31:0] ALU_result, ALU_result_q;
    logic        branch, branch_q;
`ifdef ALU_ZERO_FLAG_EN
    logic        zero, zero_q;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    rv_alu dut (
        .clock        (clock),
        .reset        (reset),
        .branch_op    (branch_op),
        .ALU_Control  (ALU_Control),
        .operand_A    (operand_A),
        .operand_B    (operand_B),
        .ALU_result   (ALU_result),
        .branch       (branch),
`ifdef ALU_ZERO_FLAG_EN
        .zero         (zero),
        .zero_q       (zero_q),
`endif
        .ALU_result_q (ALU_result_q),
        .branch_q     (branch_q)
    );

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        bop;
        logic [31:0] res;
        logic        br;
    } vec_t;

    // Reference: signed compare via sign-bit flip, SRA via fill mask
    function automatic void model(input logic [5:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic bop,
                                  output logic [31:0] r, output logic br);
        logic [31:0] flip = 32'h8000_0000;
        logic [31:0] ones = 32'hFFFF_FFFF;
        int          s    = int'(b % 32);
        logic        slt  = (a ^ flip) < (b ^ flip);
        logic        sltu = a < b;
        logic        t    = 1'b0;
        logic        is_br = 1'b1;
        r = 32'd0;
        case (c)
            6'd0:  r = a + b;
            6'd8:  r = a - b;
            6'd1:  r = a << s;
            6'd5:  r = a >> s;
            6'd13: r = (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
            6'd2:  r = {31'd0, slt};
            6'd3:  r = {31'd0, sltu};
            6'd4:  r = a ^ b;
            6'd6:  r = a | b;
            6'd7:  r = a & b;
            6'd31, 6'd63: r = a;
            default: r = 32'd0;
        endcase
        case (c)
            6'd16: t = (a == b);
            6'd17: t = (a != b);
            6'd20: t = slt;
            6'd21: t = !slt;
            6'd22: t = sltu;
            6'd23: t = !sltu;
            default: is_br = 1'b0;
        endcase
        if (is_br) r = {31'd0, t};
        br = bop && t;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if (ALU_result_q !== 32'd0 || branch_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: q=%h bq=%b want 0/0", ALU_result_q, branch_q);
        end
`ifdef ALU_ZERO_FLAG_EN
        n_checks++;
        if (zero_q !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero_q: got %b want 1", zero_q);
        end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t q[$];
        q.push_back({6'b000000, 32'd4, 32'd5, 1'b0, 32'd9, 1'b0});
        q.push_back({6'b001000, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd2, 1'b0});
        q.push_back({6'b001000, 32'h101, 32'h100, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b000000, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0});
        q.push_back({6'b000010, 32'd4, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0});
        q.push_back({6'b000010, 32'd4, 32'd5, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b000010, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0});
        q.push_back({6'b000011, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b000001, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0});
        q.push_back({6'b000101, 32'h11, 32'd5, 1'b0, 32'd0, 1'b0});
        q.push_back({6'b000101, 32'h11, 32'd1, 1'b0, 32'd8, 1'b0});
        q.push_back({6'b000101, 32'h11, 32'd2, 1'b0, 32'd4, 1'b0});
        q.push_back({6'b001101, 32'hFFFFFFFC, 32'd5, 1'b0, 32'hFFFFFFFF, 1'b0});
        q.push_back({6'b001101, 32'h10000, 32'hFFFFF010, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b001101, 32'h11, 32'd2, 1'b0, 32'd4, 1'b0});
        q.push_back({6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0});
        q.push_back({6'b010001, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010100, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010101, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0});
        q.push_back({6'b010101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010110, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010111, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0});
        q.push_back({6'b010111, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1});
        q.push_back({6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b000010, 32'd4, 32'd5, 1'b1, 32'd1, 1'b0});
        q.push_back({6'b000100, 32'd1, 32'h101, 1'b0, 32'd256, 1'b0});
        q.push_back({6'b000110, 32'd1, 32'h101, 1'b0, 32'd257, 1'b0});
        q.push_back({6'b000111, 32'd1, 32'h10101, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b011111, 32'd1, 32'd7, 1'b0, 32'd1, 1'b0});
        q.push_back({6'b111111, 32'hFFFFFFFF, 32'd3, 1'b0, 32'hFFFFFFFF, 1'b0});
        q.push_back({6'b001111, 32'd5, 32'd3, 1'b1, 32'd0, 1'b0});
        foreach (q[i]) begin
            ALU_Control = q[i].ctrl; operand_A = q[i].a;
            operand_B = q[i].b;      branch_op = q[i].bop;
            #1;
            n_checks++;
            if (ALU_result !== q[i].res || branch !== q[i].br) begin
                n_fail++;
                $display("FAIL directed[%0d] ctrl=%b: got %h/%b want %h/%b",
                         i, q[i].ctrl, ALU_result, branch, q[i].res, q[i].br);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  codes[18] = '{6'd0, 6'd8, 6'd1, 6'd5, 6'd13, 6'd2, 6'd3, 6'd4, 6'd6,
                                   6'd7, 6'd16, 6'd17, 6'd20, 6'd21, 6'd22, 6'd23, 6'd31, 6'd63};
        logic [31:0] er;
        logic        eb;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            ALU_Control = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 17)];
            operand_A = $urandom;
            operand_B = ($urandom_range(0, 3) == 0) ? operand_A : $urandom;
            branch_op = 1'($urandom);
            model(ALU_Control, operand_A, operand_B, branch_op, er, eb);
            #1;
            n_checks++;
            if (ALU_result !== er || branch !== eb) begin
                n_fail++;
                $display("FAIL random_comb ctrl=%b a=%h b=%h: got %h/%b want %h/%b",
                         ALU_Control, operand_A, operand_B, ALU_result, branch, er, eb);
            end
`ifdef ALU_ZERO_FLAG_EN
            n_checks++;
            if (zero !== (er == 32'd0)) begin
                n_fail++;
                $display("FAIL random_zero: got %b want %b", zero, (er == 32'd0));
            end
`endif
            @(posedge clock);
            #1;
            n_checks++;
            if (ALU_result_q !== er || branch_q !== eb) begin
                n_fail++;
                $display("FAIL random_reg: got %h/%b want %h/%b", ALU_result_q, branch_q, er, eb);
            end
        end
    endtask

    task automatic test_registers();
        // Branch-taken BEQ captured, then ADD 4+5 with mid-cycle reset
        @(negedge clock);
        ALU_Control = 6'b010000; operand_A = 32'd3; operand_B = 32'd3; branch_op = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (ALU_result_q !== 32'd1 || branch_q !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_capture_branch: got %h/%b want 1/1", ALU_result_q, branch_q);
        end
        @(negedge clock);
        ALU_Control = 6'b000000; operand_A = 32'd4; operand_B = 32'd5; branch_op = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ALU_result_q !== 32'd0 || branch_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_async_clear: got %h/%b want 0/0", ALU_result_q, branch_q);
        end
        n_checks++;
        if (ALU_result !== 32'd9) begin
            n_fail++;
            $display("FAIL comb_live_in_reset: got %h want 9", ALU_result);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (ALU_result_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reg_hold_after_release: got %h want 0", ALU_result_q);
        end
        @(posedge clock); #1;
        n_checks++;
        if (ALU_result_q !== 32'd9 || branch_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_first_capture: got %h/%b want 9/0", ALU_result_q, branch_q);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_registers();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
